// File: rtl/turf_fragment_rx.sv
// TURF fragment reassembler: checks fragment tags and order, strips them and emits one
// contiguous event data stream followed by a per-event status word.
module turf_fragment_rx #(
  parameter logic [15:0] CONSTANT_0   = 16'hDA7A,
  parameter logic [5:0]  CONSTANT_1   = 6'h00,
  parameter int unsigned ERR_CNT_BITS = 16
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [63:0]             s_payload_tdata,
  input  logic                    s_payload_tvalid,
  output logic                    s_payload_tready,
  input  logic [7:0]              s_payload_tkeep,
  input  logic                    s_payload_tlast,
  output logic [63:0]             m_data_tdata,
  output logic                    m_data_tvalid,
  input  logic                    m_data_tready,
  output logic [7:0]              m_data_tkeep,
  output logic                    m_data_tlast,
  output logic                    m_data_tuser,
  output logic [31:0]             m_status_tdata,
  output logic                    m_status_tvalid,
  input  logic                    m_status_tready,
  output logic                    m_status_tuser,
  output logic [ERR_CNT_BITS-1:0] err_count_o,
  output logic                    busy_o
);

  typedef enum logic [2:0] {StTag, StStream, StDrop, StFlush, StStatus} state_e;

  state_e            state_q, state_d;
  logic              in_event_q, in_event_d;
  logic [9:0]        exp_frag_q, exp_frag_d;
  logic [11:0]       addr_q, addr_d;
  logic [19:0]       len_q, len_d;
  logic [19:0]       rem_q, rem_d;
  logic              pending_q, pending_d;
  logic              abort_q, abort_d;
  logic              drop_after_q, drop_after_d;
  logic [ERR_CNT_BITS-1:0] err_q;
  logic              err_inc;

  // Byte count comes from the tag, so tkeep on the input side carries no information.
  logic unused_tkeep;
  assign unused_tkeep = ^s_payload_tkeep;

  logic        tag_ok;
  logic [9:0]  tag_frag;
  logic [11:0] tag_addr;
  logic [19:0] tag_len;
  logic        final_beat;
  logic [7:0]  keep_stream;

  assign tag_ok      = (s_payload_tdata[63:42] == {CONSTANT_0, CONSTANT_1});
  assign tag_frag    = s_payload_tdata[41:32];
  assign tag_addr    = s_payload_tdata[31:20];
  assign tag_len     = s_payload_tdata[19:0];
  assign final_beat  = (rem_q <= 20'd8);
  assign keep_stream = (rem_q >= 20'd8) ? 8'hFF : ((8'h01 << rem_q[2:0]) - 8'h01);

  always_comb begin
    state_d          = state_q;
    in_event_d       = in_event_q;
    exp_frag_d       = exp_frag_q;
    addr_d           = addr_q;
    len_d            = len_q;
    rem_d            = rem_q;
    pending_d        = pending_q;
    abort_d          = abort_q;
    drop_after_d     = drop_after_q;
    err_inc          = 1'b0;
    s_payload_tready = 1'b0;
    m_data_tdata     = 64'h0;
    m_data_tvalid    = 1'b0;
    m_data_tkeep     = 8'h00;
    m_data_tlast     = 1'b0;
    m_data_tuser     = 1'b0;
    m_status_tdata   = 32'h0;
    m_status_tvalid  = 1'b0;
    m_status_tuser   = 1'b0;

    case (state_q)
      StTag: begin
        s_payload_tready = 1'b1;
        if (s_payload_tvalid) begin
          if (!tag_ok) begin
            err_inc = 1'b1;
            state_d = s_payload_tlast ? StTag : StDrop;
          end else if (!in_event_q) begin
            if (tag_frag != 10'd0) begin
              err_inc = 1'b1;
              state_d = s_payload_tlast ? StTag : StDrop;
            end else begin
              addr_d     = tag_addr;
              len_d      = tag_len;
              rem_d      = tag_len;
              exp_frag_d = 10'd1;
              in_event_d = 1'b1;
              abort_d    = 1'b0;
              if (tag_len == 20'd0) begin
                pending_d = 1'b1;
                state_d   = s_payload_tlast ? StStatus : StDrop;
              end else begin
                state_d = s_payload_tlast ? StTag : StStream;
              end
            end
          end else if ({tag_frag, tag_addr, tag_len} == {exp_frag_q, addr_q, len_q}) begin
            exp_frag_d = exp_frag_q + 10'd1;
            state_d    = s_payload_tlast ? StTag : StStream;
          end else begin
            err_inc      = 1'b1;
            pending_d    = 1'b1;
            abort_d      = 1'b1;
            drop_after_d = !s_payload_tlast;
            state_d      = StFlush;
          end
        end
      end
      StStream: begin
        s_payload_tready = m_data_tready;
        m_data_tvalid    = s_payload_tvalid;
        m_data_tdata     = s_payload_tdata;
        m_data_tkeep     = keep_stream;
        m_data_tlast     = final_beat;
        if (s_payload_tvalid && m_data_tready) begin
          rem_d = final_beat ? 20'd0 : rem_q - 20'd8;
          if (final_beat) begin
            pending_d = 1'b1;
            // Beats past the declared length are an overrun.
            if (s_payload_tlast) begin
              state_d = StStatus;
            end else begin
              err_inc = 1'b1;
              state_d = StDrop;
            end
          end else if (s_payload_tlast) begin
            state_d = StTag;
          end
        end
      end
      StDrop: begin
        s_payload_tready = 1'b1;
        if (s_payload_tvalid && s_payload_tlast) begin
          state_d = pending_q ? StStatus : StTag;
        end
      end
      StFlush: begin
        // Zero-byte terminator so the buffer writer closes the aborted event.
        m_data_tvalid = 1'b1;
        m_data_tlast  = 1'b1;
        m_data_tuser  = 1'b1;
        if (m_data_tready) begin
          state_d = drop_after_q ? StDrop : StStatus;
        end
      end
      StStatus: begin
        m_status_tvalid = 1'b1;
        m_status_tdata  = {addr_q, len_q};
        m_status_tuser  = abort_q;
        if (m_status_tready) begin
          in_event_d = 1'b0;
          exp_frag_d = 10'd0;
          pending_d  = 1'b0;
          abort_d    = 1'b0;
          state_d    = StTag;
        end
      end
      default: state_d = StTag;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= StTag;
      in_event_q   <= 1'b0;
      exp_frag_q   <= 10'd0;
      addr_q       <= 12'd0;
      len_q        <= 20'd0;
      rem_q        <= 20'd0;
      pending_q    <= 1'b0;
      abort_q      <= 1'b0;
      drop_after_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_event_q   <= in_event_d;
      exp_frag_q   <= exp_frag_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      pending_q    <= pending_d;
      abort_q      <= abort_d;
      drop_after_q <= drop_after_d;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      err_q <= '0;
    end else if (err_inc && (err_q != {ERR_CNT_BITS{1'b1}})) begin
      err_q <= err_q + ERR_CNT_BITS'(1);
    end
  end

  assign err_count_o = err_q;
  assign busy_o      = in_event_q;

endmodule

// File: tb/tb_turf_fragment_rx.sv
// Bench for turf_fragment_rx: datagram-level reference model, randomized data and handshakes.
module tb_turf_fragment_rx;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [63:0] s_payload_tdata = '0;
  logic        s_payload_tvalid = 1'b0;
  logic        s_payload_tready;
  logic [7:0]  s_payload_tkeep = '0;
  logic        s_payload_tlast = 1'b0;
  logic [63:0] m_data_tdata;
  logic        m_data_tvalid;
  logic        m_data_tready = 1'b1;
  logic [7:0]  m_data_tkeep;
  logic        m_data_tlast;
  logic        m_data_tuser;
  logic [31:0] m_status_tdata;
  logic        m_status_tvalid;
  logic        m_status_tready = 1'b1;
  logic        m_status_tuser;
  logic [15:0] err_count_o;
  logic        busy_o;

  turf_fragment_rx dut (
    .aclk             (aclk),
    .areset           (areset),
    .s_payload_tdata  (s_payload_tdata),
    .s_payload_tvalid (s_payload_tvalid),
    .s_payload_tready (s_payload_tready),
    .s_payload_tkeep  (s_payload_tkeep),
    .s_payload_tlast  (s_payload_tlast),
    .m_data_tdata     (m_data_tdata),
    .m_data_tvalid    (m_data_tvalid),
    .m_data_tready    (m_data_tready),
    .m_data_tkeep     (m_data_tkeep),
    .m_data_tlast     (m_data_tlast),
    .m_data_tuser     (m_data_tuser),
    .m_status_tdata   (m_status_tdata),
    .m_status_tvalid  (m_status_tvalid),
    .m_status_tready  (m_status_tready),
    .m_status_tuser   (m_status_tuser),
    .err_count_o      (err_count_o),
    .busy_o           (busy_o)
  );

  always #5 aclk = ~aclk;

  int n_pass = 0;
  int n_total = 0;
  int rdy_mode = 0;   // 0 always ready, 1 random, 2 toggling
  int hold_left = 0;  // cycles to refuse a pending status
  bit gap_en = 1'b0;
  int mirror_bad = 0;

  // Beat record: {tuser, tlast, tkeep, tdata}; status record: {tuser, tdata}
  logic [73:0] exp_beats[$], act_beats[$];
  logic [32:0] exp_st[$], act_st[$];
  logic [63:0] dg_tag[$], dg_data[$];
  int          dg_n[$], dg_base[$];

  // Reference model state, advanced one whole datagram at a time
  bit          m_in_event;
  logic [9:0]  m_exp;
  logic [11:0] m_addr;
  logic [19:0] m_len;
  int          m_rem;
  int          m_err;

  always @(posedge aclk) begin
    #1;
    case (rdy_mode)
      0:       m_data_tready = 1'b1;
      1:       m_data_tready = 1'($urandom_range(0, 1));
      default: m_data_tready = ~m_data_tready;
    endcase
    if (hold_left > 0 && m_status_tvalid) begin
      m_status_tready = 1'b0;
      hold_left--;
    end else begin
      m_status_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  always @(negedge aclk) begin
    if (!areset) begin
      if (m_data_tvalid && m_data_tready)
        act_beats.push_back({m_data_tuser, m_data_tlast, m_data_tkeep, m_data_tdata});
      if (m_status_tvalid && m_status_tready)
        act_st.push_back({m_status_tuser, m_status_tdata});
      if (m_data_tvalid && !m_data_tuser && (s_payload_tready !== m_data_tready))
        mirror_bad++;
    end
  end

  function automatic logic [63:0] mk_tag(input logic [9:0] f, input logic [11:0] a,
                                         input logic [19:0] l);
    return {16'hDA7A, 6'h00, f, a, l};
  endfunction

  function automatic int beat_diff();
    int n = (act_beats.size() > exp_beats.size()) ? act_beats.size() : exp_beats.size();
    for (int i = 0; i < n; i++)
      if (i >= act_beats.size() || i >= exp_beats.size() || act_beats[i] !== exp_beats[i])
        return i;
    return -1;
  endfunction

  function automatic int st_diff();
    int n = (act_st.size() > exp_st.size()) ? act_st.size() : exp_st.size();
    for (int i = 0; i < n; i++)
      if (i >= act_st.size() || i >= exp_st.size() || act_st[i] !== exp_st[i]) return i;
    return -1;
  endfunction

  function automatic logic [73:0] act_b(input int i);
    return (i >= 0 && i < act_beats.size()) ? act_beats[i] : '1;
  endfunction
  function automatic logic [73:0] exp_b(input int i);
    return (i >= 0 && i < exp_beats.size()) ? exp_beats[i] : '1;
  endfunction
  function automatic logic [32:0] act_s(input int i);
    return (i >= 0 && i < act_st.size()) ? act_st[i] : '1;
  endfunction
  function automatic logic [32:0] exp_s(input int i);
    return (i >= 0 && i < exp_st.size()) ? exp_st[i] : '1;
  endfunction

  task automatic model_close(input bit abort);
    exp_st.push_back({abort, m_addr, m_len});
    m_in_event = 1'b0;
    m_exp      = 10'd0;
  endtask

  task automatic model_dgram(input logic [63:0] tag, input int n, input int base);
    logic [9:0]  f = tag[41:32];
    logic [11:0] a = tag[31:20];
    logic [19:0] l = tag[19:0];
    if (tag[63:42] != {16'hDA7A, 6'h00}) begin
      m_err++;
      return;
    end
    if (!m_in_event) begin
      if (f != 10'd0) begin
        m_err++;
        return;
      end
      m_in_event = 1'b1;
      m_addr = a;
      m_len  = l;
      m_rem  = int'(l);
      m_exp  = 10'd1;
      if (l == 20'd0) begin
        model_close(1'b0);
        return;
      end
    end else if (f == m_exp && a == m_addr && l == m_len) begin
      m_exp = m_exp + 10'd1;
    end else begin
      m_err++;
      exp_beats.push_back({1'b1, 1'b1, 8'h00, 64'h0});
      model_close(1'b1);
      return;
    end
    for (int i = 0; i < n; i++) begin
      int take = (m_rem > 8) ? 8 : m_rem;
      logic [7:0] keep = 8'((1 << take) - 1);
      exp_beats.push_back({1'b0, (take == m_rem), keep, dg_data[base + i]});
      m_rem -= take;
      if (m_rem == 0) begin
        model_close(1'b0);
        if (i != n - 1) m_err++;
        return;
      end
    end
  endtask

  task automatic add_dg(input logic [63:0] tag, input int n);
    dg_tag.push_back(tag);
    dg_n.push_back(n);
    dg_base.push_back(dg_data.size());
    for (int i = 0; i < n; i++) dg_data.push_back({$urandom, $urandom});
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    int t = 0;
    if (gap_en) repeat ($urandom_range(0, 2)) begin
      @(posedge aclk);
      #1;
    end
    s_payload_tdata  = d;
    s_payload_tlast  = last;
    s_payload_tkeep  = 8'($urandom);
    s_payload_tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      if (s_payload_tready) break;
      t++;
      if (t > 3000) begin
        n_total++;
        $display("FAIL send_beat timeout: tready got 0 for %0d cycles, want 1", t);
        break;
      end
    end
    @(posedge aclk);
    #1;
    s_payload_tvalid = 1'b0;
    s_payload_tlast  = 1'b0;
  endtask

  task automatic run_traffic();
    int t = 0;
    act_beats.delete(); exp_beats.delete(); act_st.delete(); exp_st.delete();
    foreach (dg_tag[i]) model_dgram(dg_tag[i], dg_n[i], dg_base[i]);
    foreach (dg_tag[i]) begin
      send_beat(dg_tag[i], dg_n[i] == 0);
      for (int j = 0; j < dg_n[i]; j++) send_beat(dg_data[dg_base[i] + j], j == dg_n[i] - 1);
    end
    while ((act_beats.size() < exp_beats.size() || act_st.size() < exp_st.size()) && t < 3000) begin
      @(negedge aclk);
      t++;
    end
    repeat (8) @(negedge aclk);
    dg_tag.delete(); dg_n.delete(); dg_base.delete(); dg_data.delete();
  endtask

  task automatic apply_reset();
    areset = 1'b1;
    s_payload_tvalid = 1'b0;
    s_payload_tlast  = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;
    m_in_event = 1'b0;
    m_exp = 10'd0;
    m_err = 0;
    mirror_bad = 0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    #1;
    n_total++;
    if ({m_data_tvalid, m_data_tlast, m_data_tuser, m_status_tvalid, m_status_tuser, busy_o} !== 6'b0)
      $display("FAIL reset flags: got %b, want 000000",
               {m_data_tvalid, m_data_tlast, m_data_tuser, m_status_tvalid, m_status_tuser, busy_o});
    else n_pass++;
    n_total++;
    if (m_status_tdata !== 32'h0) $display("FAIL reset status: got %h, want 0", m_status_tdata);
    else n_pass++;
    n_total++;
    if (err_count_o !== 16'h0) $display("FAIL reset err: got %0d, want 0", err_count_o);
    else n_pass++;
    n_total++;
    if (s_payload_tready !== 1'b1) $display("FAIL reset tready: got %b, want 1", s_payload_tready);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_single();
    int d;
    logic [23:0] keeps = '1;
    apply_reset();
    rdy_mode = 0; gap_en = 0;
    add_dg(mk_tag(10'd0, 12'h123, 20'd20), 3);
    run_traffic();
    n_total++; d = beat_diff();
    if (d >= 0) $display("FAIL single beat %0d: got %h, want %h", d, act_b(d), exp_b(d)); else n_pass++;
    n_total++; d = st_diff();
    if (d >= 0) $display("FAIL single status %0d: got %h, want %h", d, act_s(d), exp_s(d)); else n_pass++;
    n_total++;
    if (err_count_o !== 16'(m_err)) $display("FAIL single err: got %0d, want %0d", err_count_o, m_err);
    else n_pass++;
    if (act_beats.size() == 3) keeps = {act_beats[0][71:64], act_beats[1][71:64], act_beats[2][71:64]};
    n_total++;
    if (keeps !== 24'hFFFF0F) $display("FAIL single keeps: got %h, want ffff0f", keeps); else n_pass++;
    n_total++;
    if (act_s(0) !== 33'h0_1230_0014) $display("FAIL single word: got %h, want 012300014", act_s(0));
    else n_pass++;
  endtask

  task automatic test_multi_frag();
    int d;
    apply_reset();
    rdy_mode = 1; gap_en = 1;
    add_dg(mk_tag(10'd0, 12'h0A5, 20'd24), 2);
    add_dg(mk_tag(10'd1, 12'h0A5, 20'd24), 1);
    run_traffic();
    n_total++; d = beat_diff();
    if (d >= 0) $display("FAIL multi beat %0d: got %h, want %h", d, act_b(d), exp_b(d)); else n_pass++;
    n_total++; d = st_diff();
    if (d >= 0) $display("FAIL multi status %0d: got %h, want %h", d, act_s(d), exp_s(d)); else n_pass++;
    n_total++;
    if (err_count_o !== 16'd0) $display("FAIL multi err: got %0d, want 0", err_count_o); else n_pass++;
  endtask

  task automatic test_abort();
    int d;
    apply_reset();
    rdy_mode = 1; gap_en = 1;
    add_dg(mk_tag(10'd0, 12'h777, 20'd64), 2);
    add_dg(mk_tag(10'd2, 12'h777, 20'd64), 3);
    run_traffic();
    n_total++; d = beat_diff();
    if (d >= 0) $display("FAIL abort beat %0d: got %h, want %h", d, act_b(d), exp_b(d)); else n_pass++;
    n_total++; d = st_diff();
    if (d >= 0) $display("FAIL abort status %0d: got %h, want %h", d, act_s(d), exp_s(d)); else n_pass++;
    n_total++;
    if (act_b(2) !== {1'b1, 1'b1, 8'h00, 64'h0})
      $display("FAIL abort flush: got %h, want %h", act_b(2), {1'b1, 1'b1, 8'h00, 64'h0});
    else n_pass++;
    n_total++;
    if (err_count_o !== 16'd1) $display("FAIL abort err: got %0d, want 1", err_count_o); else n_pass++;
  endtask

  task automatic test_bad_tag();
    int d;
    apply_reset();
    rdy_mode = 0; gap_en = 1;
    add_dg({16'hBEEF, 6'h00, 10'd0, 12'h010, 20'd12}, 2);
    add_dg(mk_tag(10'd0, 12'h010, 20'd12), 2);
    run_traffic();
    n_total++; d = beat_diff();
    if (d >= 0) $display("FAIL badtag beat %0d: got %h, want %h", d, act_b(d), exp_b(d)); else n_pass++;
    n_total++; d = st_diff();
    if (d >= 0) $display("FAIL badtag status %0d: got %h, want %h", d, act_s(d), exp_s(d)); else n_pass++;
    n_total++;
    if (err_count_o !== 16'd1) $display("FAIL badtag err: got %0d, want 1", err_count_o); else n_pass++;
  endtask

  task automatic test_back_pressure();
    int d;
    int t = 0;
    int bad = 0;
    apply_reset();
    rdy_mode = 2; gap_en = 1; hold_left = 10;
    add_dg(mk_tag(10'd0, 12'h3C3, 20'd40), 3);
    add_dg(mk_tag(10'd1, 12'h3C3, 20'd40), 2);
    add_dg(mk_tag(10'd0, 12'h111, 20'd9), 2);
    fork
      run_traffic();
      begin
        while (m_status_tvalid !== 1'b1 && t < 3000) begin
          @(negedge aclk);
          t++;
        end
        repeat (10) begin
          if (s_payload_tready !== 1'b0 || m_status_tvalid !== 1'b1) bad++;
          @(negedge aclk);
        end
      end
    join
    n_total++;
    if (bad != 0 || t >= 3000)
      $display("FAIL bp status hold: got %0d bad cycles (wait %0d), want 0", bad, t);
    else n_pass++;
    n_total++; d = beat_diff();
    if (d >= 0) $display("FAIL bp beat %0d: got %h, want %h", d, act_b(d), exp_b(d)); else n_pass++;
    n_total++; d = st_diff();
    if (d >= 0) $display("FAIL bp status %0d: got %h, want %h", d, act_s(d), exp_s(d)); else n_pass++;
    n_total++;
    if (mirror_bad != 0) $display("FAIL bp mirror: got %0d mismatches, want 0", mirror_bad);
    else n_pass++;
    hold_left = 0;
  endtask

  task automatic test_zero_len_reset();
    int d;
    apply_reset();
    rdy_mode = 0; gap_en = 0;
    add_dg(mk_tag(10'd0, 12'hABC, 20'd0), 0);
    run_traffic();
    n_total++; d = beat_diff();
    if (d >= 0) $display("FAIL zlen beat %0d: got %h, want %h", d, act_b(d), exp_b(d)); else n_pass++;
    n_total++;
    if (act_st.size() != 1 || act_s(0) !== 33'h0_ABC0_0000)
      $display("FAIL zlen status: got %h (n=%0d), want 0abc00000", act_s(0), act_st.size());
    else n_pass++;
    send_beat(mk_tag(10'd0, 12'h222, 20'd32), 1'b0);
    s_payload_tdata  = {$urandom, $urandom};
    s_payload_tvalid = 1'b1;
    @(negedge aclk);
    n_total++;
    if (m_data_tvalid !== 1'b1) $display("FAIL midstream valid: got %b, want 1", m_data_tvalid);
    else n_pass++;
    #2;
    areset = 1'b1;
    #1;
    n_total++;
    if ({m_data_tvalid, m_status_tvalid, busy_o} !== 3'b000)
      $display("FAIL async reset: got %b, want 000", {m_data_tvalid, m_status_tvalid, busy_o});
    else n_pass++;
    apply_reset();
    add_dg(mk_tag(10'd0, 12'h333, 20'd17), 3);
    run_traffic();
    n_total++; d = beat_diff();
    if (d >= 0) $display("FAIL postrst beat %0d: got %h, want %h", d, act_b(d), exp_b(d)); else n_pass++;
    n_total++; d = st_diff();
    if (d >= 0) $display("FAIL postrst status %0d: got %h, want %h", d, act_s(d), exp_s(d)); else n_pass++;
  endtask

  task automatic test_frag_wrap();
    int d;
    apply_reset();
    rdy_mode = 0; gap_en = 0;
    for (int i = 0; i < 1024; i++) add_dg(mk_tag(10'(i), 12'h5A5, 20'd16), 0);
    add_dg(mk_tag(10'd0, 12'h5A5, 20'd16), 2);
    run_traffic();
    n_total++; d = beat_diff();
    if (d >= 0) $display("FAIL wrap beat %0d: got %h, want %h", d, act_b(d), exp_b(d)); else n_pass++;
    n_total++; d = st_diff();
    if (d >= 0) $display("FAIL wrap status %0d: got %h, want %h", d, act_s(d), exp_s(d)); else n_pass++;
    n_total++;
    if (err_count_o !== 16'(m_err)) $display("FAIL wrap err: got %0d, want %0d", err_count_o, m_err);
    else n_pass++;
  endtask

  task automatic test_random();
    int d, nb, sent, fr, k, extra;
    logic [11:0] a;
    logic [19:0] l;
    logic [9:0]  f;
    apply_reset();
    rdy_mode = 1; gap_en = 1;
    for (int e = 0; e < 30; e++) begin
      a = 12'($urandom);
      l = 20'($urandom_range(0, 60));
      nb = (int'(l) + 7) / 8;
      sent = 0;
      fr = 0;
      do begin
        if ($urandom_range(0, 11) == 0) add_dg({16'hBEEF, 48'($urandom)}, $urandom_range(0, 2));
        if (nb == sent) k = 0;
        else k = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, nb - sent);
        f = 10'(fr);
        if ($urandom_range(0, 14) == 0) f = f + 10'd1;
        extra = (sent + k == nb && $urandom_range(0, 7) == 0) ? 1 : 0;
        add_dg(mk_tag(f, a, l), k + extra);
        sent += k;
        fr++;
      end while (sent < nb);
    end
    run_traffic();
    n_total++; d = beat_diff();
    if (d >= 0) $display("FAIL rand beat %0d: got %h, want %h (n %0d/%0d)", d, act_b(d), exp_b(d),
                         act_beats.size(), exp_beats.size());
    else n_pass++;
    n_total++; d = st_diff();
    if (d >= 0) $display("FAIL rand status %0d: got %h, want %h (n %0d/%0d)", d, act_s(d), exp_s(d),
                         act_st.size(), exp_st.size());
    else n_pass++;
    n_total++;
    if (err_count_o !== 16'(m_err)) $display("FAIL rand err: got %0d, want %0d", err_count_o, m_err);
    else n_pass++;
    n_total++;
    if (mirror_bad != 0) $display("FAIL rand mirror: got %0d mismatches, want 0", mirror_bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_frag();
    test_abort();
    test_bad_tag();
    test_back_pressure();
    test_zero_len_reset();
    test_frag_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
